arith_compare_pipe: RTL

Parametrised, pipelined successor to the team's 4-bit combinational add/subtract/compare unit. Accepts operand pairs over a valid/ready handshake and computes the selected operation in a two-stage pipeline with backpressure. Adds min/max, an internal running accumulator and carry/borrow reporting. Sits between an operand source (register file or stream) and any downstream consumer that may stall.

---
 rtl/arith_compare_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/arith_compare_pipe.sv
`default_nettype none
// ============================================================================
// Module   : arith_compare_pipe
// Brief    : Two-stage valid/ready add/sub/compare/min/max/accumulate pipeline.
//            Optional saturation: define ARITH_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arith_compare_pipe #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flag,
  output logic             carry
);

  localparam logic [2:0] c_OP_ADD  = 3'b000;
  localparam logic [2:0] c_OP_SUB  = 3'b001;
  localparam logic [2:0] c_OP_CMP  = 3'b010;
  localparam logic [2:0] c_OP_ZERO = 3'b011;
  localparam logic [2:0] c_OP_ACC  = 3'b100;
  localparam logic [2:0] c_OP_CLR  = 3'b101;
  localparam logic [2:0] c_OP_MIN  = 3'b110;
  localparam logic [2:0] c_OP_MAX  = 3'b111;

  // Stage 1 registers
  logic             v1_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       ctrl_q;

  // Stage 2 registers and accumulator
  logic             v2_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       flag_q, flag_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic w_s2_load;
  logic w_in_fire;

  assign w_s2_load = v1_q && (!v2_q || out_ready);
  assign in_ready  = !v1_q || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage 2 datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_acc_sum;
  logic [WIDTH-1:0] w_a_key, w_b_key;
  logic             w_lt, w_eq, w_gt;
  logic [WIDTH-1:0] w_add_res, w_sub_res, w_acc_res;

  assign w_sum     = {1'b0, a_q} + {1'b0, b_q};
  assign w_diff    = {1'b0, a_q} - {1'b0, b_q};
  assign w_acc_sum = {1'b0, acc_q} + {1'b0, a_q};

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_a_key = {a_q[WIDTH-1] ^ SIGNED, a_q[WIDTH-2:0]};
  assign w_b_key = {b_q[WIDTH-1] ^ SIGNED, b_q[WIDTH-2:0]};
  assign w_lt    = w_a_key < w_b_key;
  assign w_eq    = a_q == b_q;
  assign w_gt    = !w_lt && !w_eq;

`ifdef ARITH_SAT_EN
  assign w_add_res = w_sum[WIDTH]     ? '1 : w_sum[WIDTH-1:0];
  assign w_sub_res = w_diff[WIDTH]    ? '0 : w_diff[WIDTH-1:0];
  assign w_acc_res = w_acc_sum[WIDTH] ? '1 : w_acc_sum[WIDTH-1:0];
`else
  assign w_add_res = w_sum[WIDTH-1:0];
  assign w_sub_res = w_diff[WIDTH-1:0];
  assign w_acc_res = w_acc_sum[WIDTH-1:0];
`endif

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    acc_d   = acc_q;
    flag_d  = {w_gt, w_eq, w_lt};
    case (ctrl_q)
      c_OP_ADD: begin
        res_d   = w_add_res;
        carry_d = w_sum[WIDTH];
      end
      c_OP_SUB: begin
        res_d   = w_sub_res;
        carry_d = w_diff[WIDTH];
      end
      c_OP_CMP:  res_d = WIDTH'({w_gt, w_eq, w_lt});
      c_OP_ZERO: res_d = '0;
      c_OP_ACC: begin
        res_d   = w_acc_res;
        carry_d = w_acc_sum[WIDTH];
        acc_d   = w_acc_res;
      end
      c_OP_CLR: begin
        res_d = acc_q;
        acc_d = '0;
      end
      c_OP_MIN: res_d = w_lt ? a_q : b_q;
      c_OP_MAX: res_d = w_gt ? a_q : b_q;
      default:  res_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      ctrl_q <= '0;
    end else if (w_in_fire) begin
      v1_q   <= 1'b1;
      a_q    <= A;
      b_q    <= B;
      ctrl_q <= ctrl;
    end else if (w_s2_load) begin
      v1_q <= 1'b0;
    end
  end

  // acc only advances when its ACC/CLR beat actually moves into stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      res_q   <= '0;
      flag_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
    end else if (w_s2_load) begin
      v2_q    <= 1'b1;
      res_q   <= res_d;
      flag_q  <= flag_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
    end else if (out_ready) begin
      v2_q <= 1'b0;
    end
  end

  assign out_valid = v2_q;
  assign result    = res_q;
  assign flag      = flag_q;
  assign carry     = carry_q;

endmodule
`default_nettype wire
